mdc_sched: RTL

Two-requester scheduler that shares a single MDC (matrix determinant calculator) instance. It grants the MDC to one requester at a time using round-robin arbitration and forwards that requester's 16-word matrix stream to the MDC input port with registered timing. It waits for the MDC result under a timeout, then returns the result to the owning requester. It sits between the two job sources and the MDC instance in the top-level datapath.

---
 rtl/mdc_sched_if.sv | 47 ++++
 rtl/mdc_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mdc_sched_if.sv
// mdc_sched_if: bundles the requester, MDC and response signals of mdc_sched.
//   master : scheduler side (drives grants, MDC input stream, responses)
//   slave  : environment side (requesters and the MDC instance)
// Signals:
//   rq_req/rq_gnt             job request / stream ownership, one bit per requester
//   rq{0,1}_valid/data/mode   matrix word streams from requester 0 and 1
//   mdc_in_valid/data/mode    forwarded stream into the MDC
//   mdc_out_valid/data        MDC result
//   rsp_valid/data/err        result strobe back to the owning requester
//   proto_err                 sticky stream-gap flag
interface mdc_sched_if #(
  parameter int unsigned DATA_W = 15,
  parameter int unsigned MODE_W = 9,
  parameter int unsigned RES_W  = 207
);
  logic [1:0]        rq_req;
  logic [1:0]        rq_gnt;
  logic              rq0_valid;
  logic [DATA_W-1:0] rq0_data;
  logic [MODE_W-1:0] rq0_mode;
  logic              rq1_valid;
  logic [DATA_W-1:0] rq1_data;
  logic [MODE_W-1:0] rq1_mode;
  logic              mdc_in_valid;
  logic [DATA_W-1:0] mdc_in_data;
  logic [MODE_W-1:0] mdc_in_mode;
  logic              mdc_out_valid;
  logic [RES_W-1:0]  mdc_out_data;
  logic [1:0]        rsp_valid;
  logic [RES_W-1:0]  rsp_data;
  logic              rsp_err;
  logic              proto_err;

  modport master (
    input  rq_req, rq0_valid, rq0_data, rq0_mode, rq1_valid, rq1_data, rq1_mode,
    input  mdc_out_valid, mdc_out_data,
    output rq_gnt, mdc_in_valid, mdc_in_data, mdc_in_mode,
    output rsp_valid, rsp_data, rsp_err, proto_err
  );

  modport slave (
    output rq_req, rq0_valid, rq0_data, rq0_mode, rq1_valid, rq1_data, rq1_mode,
    output mdc_out_valid, mdc_out_data,
    input  rq_gnt, mdc_in_valid, mdc_in_data, mdc_in_mode,
    input  rsp_valid, rsp_data, rsp_err, proto_err
  );
endinterface

// File: rtl/mdc_sched.sv
// mdc_sched: round-robin scheduler sharing one MDC between two requesters.
// Grants the MDC input stream to one requester, forwards its N_WORDS-word
// matrix with one cycle of registered latency, waits for the MDC result under
// a timeout and returns it to the owner.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : mdc_sched_if.master (requests, streams, MDC port, responses)
module mdc_sched #(
  parameter int unsigned N_WORDS = 16,
  parameter int unsigned DATA_W  = 15,
  parameter int unsigned MODE_W  = 9,
  parameter int unsigned RES_W   = 207,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic         clk,
  input logic         rst_n,
  mdc_sched_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(N_WORDS + 1);
  localparam int unsigned TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_WORDS);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              padding_q, padding_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              in_valid_q, in_valid_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [MODE_W-1:0] in_mode_q, in_mode_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              perr_q, perr_d;

  // Owner-side word mux
  logic              own_valid;
  logic [DATA_W-1:0] own_data;
  logic [MODE_W-1:0] own_mode;

  assign own_valid = owner_q ? bus.rq1_valid : bus.rq0_valid;
  assign own_data  = owner_q ? bus.rq1_data  : bus.rq0_data;
  assign own_mode  = owner_q ? bus.rq1_mode  : bus.rq0_mode;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    padding_d    = padding_q;
    gnt_d        = gnt_q;
    in_valid_d   = 1'b0;
    in_data_d    = '0;
    in_mode_d    = '0;
    rsp_valid_d  = 2'b00;
    rsp_data_d   = '0;
    rsp_err_d    = 1'b0;
    perr_d       = perr_q;

    case (state_q)
      IDLE: begin
        if (bus.rq_req != 2'b00) begin
          // On a tie the requester that did not own the last job wins
          if (bus.rq_req == 2'b11) begin
            owner_d = ~last_owner_q;
          end else begin
            owner_d = bus.rq_req[1];
          end
          gnt_d     = owner_d ? 2'b10 : 2'b01;
          cnt_d     = '0;
          padding_d = 1'b0;
          state_d   = STREAM;
        end
      end

      STREAM: begin
        if ((cnt_q != '0) && (padding_q || !own_valid)) begin
          // Gap inside a burst: zero-pad the rest so the MDC sees a contiguous job
          in_valid_d = 1'b1;
          padding_d  = 1'b1;
          perr_d     = 1'b1;
          gnt_d      = 2'b00;
          cnt_d      = cnt_q + CNT_W'(1);
        end else if (own_valid) begin
          in_valid_d = 1'b1;
          in_data_d  = own_data;
          in_mode_d  = (cnt_q == '0) ? own_mode : '0;
          cnt_d      = cnt_q + CNT_W'(1);
        end
        if (cnt_d == LAST_CNT) begin
          gnt_d   = 2'b00;
          tcnt_d  = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        // A result arriving in the timeout cycle takes precedence
        if (bus.mdc_out_valid) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_data_d  = bus.mdc_out_data;
          state_d     = RESP;
        end else if (tcnt_q == TCNT_MAX) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      padding_q    <= 1'b0;
      gnt_q        <= 2'b00;
      in_valid_q   <= 1'b0;
      in_data_q    <= '0;
      in_mode_q    <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      padding_q    <= padding_d;
      gnt_q        <= gnt_d;
      in_valid_q   <= in_valid_d;
      in_data_q    <= in_data_d;
      in_mode_q    <= in_mode_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      perr_q       <= perr_d;
    end
  end

  assign bus.rq_gnt       = gnt_q;
  assign bus.mdc_in_valid = in_valid_q;
  assign bus.mdc_in_data  = in_data_q;
  assign bus.mdc_in_mode  = in_mode_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.proto_err    = perr_q;

  // Grants and response strobes never target both requesters at once
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst_n) gnt_q != 2'b11);
  a_rsp_onehot : assert property (@(posedge clk) disable iff (rst_n) rsp_valid_q != 2'b11);

endmodule
